// File: rtl/pdu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pdu_pkg                                                                    |
// | Shared state encodings and check-address map for the debug controller.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package pdu_pkg;

  typedef logic [1:0] pdu_state_t;

  localparam pdu_state_t ST_HALT = 2'd0;
  localparam pdu_state_t ST_RUN  = 2'd1;
  localparam pdu_state_t ST_STEP = 2'd2;

  // Check-address map: bit 12 selects the register file, low bits index it.
  localparam int unsigned CHK_RF_SEL_BIT = 12;
  localparam int unsigned CHK_RF_IDX_W   = 5;
  localparam logic [31:0] CHK_MEM_BASE   = 32'h0000_0000;
  localparam logic [31:0] CHK_RF_BASE    = 32'h0000_1000;

  function automatic logic chk_is_rf(input logic [31:0] addr);
    return addr[CHK_RF_SEL_BIT];
  endfunction

endpackage
`default_nettype wire

// File: rtl/pdu_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pdu_if                                                                     |
// | Host control, check-read handshake and CPU debug bus of the debug ctrl.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface pdu_if
  import pdu_pkg::*;
#(
  parameter int CNT_W = 32
);
  logic             run;
  logic             step;
  logic             halt;
  logic [31:0]      brk_pc;
  logic [31:0]      current_pc;
  logic [31:0]      next_pc;
  logic             cpu_en;
  logic             chk_req;
  logic [31:0]      chk_addr;
  logic             chk_ready;
  logic [31:0]      cpu_check_addr;
  logic [31:0]      cpu_check_data;
  logic             chk_valid;
  logic [31:0]      chk_data;
  pdu_state_t       state;
  logic             brk_hit;
  logic [CNT_W-1:0] cyc_cnt;

  modport master (
    output run, step, halt, brk_pc, current_pc, next_pc,
    output chk_req, chk_addr, cpu_check_data,
    input  cpu_en, chk_ready, cpu_check_addr, chk_valid, chk_data,
    input  state, brk_hit, cyc_cnt
  );

  modport slave (
    input  run, step, halt, brk_pc, current_pc, next_pc,
    input  chk_req, chk_addr, cpu_check_data,
    output cpu_en, chk_ready, cpu_check_addr, chk_valid, chk_data,
    output state, brk_hit, cyc_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pdu_chk_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pdu_chk_port                                                               |
// | Two-edge host check-read: latch address, then capture CPU debug data.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pdu_chk_port
  import pdu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        halted_i,
  input  logic        chk_req_i,
  input  logic [31:0] chk_addr_i,
  output logic        chk_ready_o,
  output logic [31:0] cpu_check_addr_o,
  input  logic [31:0] cpu_check_data_i,
  output logic        chk_valid_o,
  output logic [31:0] chk_data_o,
  output logic        busy_o
);

  logic        pending_q;
  logic        valid_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        w_ready;
  logic        w_accept;

  assign w_ready  = halted_i & ~pending_q;
  assign w_accept = chk_req_i & w_ready;

  // Busy covers the accept cycle too so a same-cycle step cannot slip in.
  assign busy_o           = pending_q | w_accept;
  assign chk_ready_o      = w_ready;
  assign cpu_check_addr_o = addr_q;
  assign chk_valid_o      = valid_q;
  assign chk_data_o       = data_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending_q <= 1'b0;
      valid_q   <= 1'b0;
      addr_q    <= 32'h0;
      data_q    <= 32'h0;
    end else begin
      pending_q <= w_accept;
      valid_q   <= pending_q;
      if (w_accept) begin
        addr_q <= chk_addr_i;
      end
      if (pending_q) begin
        data_q <= cpu_check_data_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pdu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pdu_ctrl                                                                   |
// | CPU run/step/halt controller with cycle counter and host check-read port.  |
// | Optional breakpoint comparator built when PDU_BRKPT_EN is defined.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pdu_ctrl
  import pdu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic rstn,
  pdu_if.slave bus
);

  pdu_state_t       state_q;
  pdu_state_t       state_d;
  logic             brk_hit_q;
  logic             brk_hit_d;
  logic [CNT_W-1:0] cyc_cnt_q;
  logic             cpu_en;
  logic             halted;
  logic             chk_busy;
  logic             brk_match;

`ifdef PDU_BRKPT_EN
  assign brk_match = (bus.next_pc == bus.brk_pc);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      brk_hit_q <= 1'b0;
    end else begin
      brk_hit_q <= brk_hit_d;
    end
  end

  logic unused_dbg;
  assign unused_dbg = ^bus.current_pc;
`else
  assign brk_match = 1'b0;
  assign brk_hit_q = 1'b0;

  logic unused_dbg;
  assign unused_dbg = ^{bus.current_pc, bus.next_pc, bus.brk_pc, brk_hit_d};
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_HALT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    brk_hit_d = brk_hit_q;
    case (state_q)
      ST_HALT: begin
        if (!chk_busy) begin
          if (bus.step) begin
            state_d = ST_STEP;
          end else if (bus.run) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (bus.halt || !bus.run) begin
          state_d = ST_HALT;
        end else if (brk_match) begin
          state_d   = ST_HALT;
          brk_hit_d = 1'b1;
        end
      end
      ST_STEP: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
    if ((state_q == ST_HALT) && (state_d != ST_HALT)) begin
      brk_hit_d = 1'b0;
    end
  end

  always_comb begin
    cpu_en = 1'b0;
    halted = 1'b0;
    case (state_q)
      ST_RUN, ST_STEP: cpu_en = 1'b1;
      ST_HALT:         halted = 1'b1;
      default:         ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cyc_cnt_q <= '0;
    end else if (cpu_en) begin
      cyc_cnt_q <= cyc_cnt_q + CNT_W'(1);
    end
  end

  pdu_chk_port u_chk (
    .clk              (clk),
    .rstn             (rstn),
    .halted_i         (halted),
    .chk_req_i        (bus.chk_req),
    .chk_addr_i       (bus.chk_addr),
    .chk_ready_o      (bus.chk_ready),
    .cpu_check_addr_o (bus.cpu_check_addr),
    .cpu_check_data_i (bus.cpu_check_data),
    .chk_valid_o      (bus.chk_valid),
    .chk_data_o       (bus.chk_data),
    .busy_o           (chk_busy)
  );

  assign bus.cpu_en  = cpu_en;
  assign bus.state   = state_q;
  assign bus.brk_hit = brk_hit_q;
  assign bus.cyc_cnt = cyc_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pdu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pdu_ctrl                                                                |
// | Directed table, corner sequences and random run against a reference model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pdu_ctrl;
  import pdu_pkg::*;

  localparam int CNT_W   = 8;
  localparam int CNT_MOD = 1 << CNT_W;
`ifdef PDU_BRKPT_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  pdu_if #(.CNT_W(CNT_W)) bus ();
  pdu_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  // Simple CPU: commits current_pc -> next_pc on each enabled edge.
  logic [31:0] cpu_pc;
  logic [31:0] pc_rst_val = 32'h0;
  logic        self_loop  = 1'b0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) cpu_pc <= pc_rst_val;
    else if (bus.cpu_en) cpu_pc <= bus.next_pc;
  end

  function automatic logic [31:0] cpu_data(input logic [31:0] a);
    if (a[CHK_RF_SEL_BIT]) begin
      case (a[4:0])
        5'd5:    return 32'hDEAD_BEEF;
        5'd3:    return 32'h1234_5678;
        default: return {27'h0ABCDE0, a[4:0]};
      endcase
    end
    return a ^ 32'hA5A5_0000;
  endfunction

  always_comb begin
    bus.current_pc     = cpu_pc;
    bus.next_pc        = self_loop ? cpu_pc : cpu_pc + 32'd4;
    bus.cpu_check_data = cpu_data(bus.cpu_check_addr);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.run      = 1'b0;
    bus.step     = 1'b0;
    bus.halt     = 1'b0;
    bus.chk_req  = 1'b0;
    bus.chk_addr = 32'h0;
  endtask

  task automatic do_reset(input logic [31:0] pc0);
    pc_rst_val = pc0;
    self_loop  = 1'b0;
    idle();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // Reference model: spec rules applied per edge, reads tracked in a queue.
  int          m_state;
  bit          m_brk;
  int          m_cnt;
  bit          m_valid;
  logic [31:0] m_data;
  logic [31:0] m_addr;
  logic [31:0] rdq[$];

  task automatic model_reset();
    m_state = 0; m_brk = 0; m_cnt = 0; m_valid = 0;
    m_data = 32'h0; m_addr = 32'h0; rdq.delete();
  endtask

  task automatic model_edge();
    bit rdy, acc, busy;
    int ns;
    rdy  = (m_state == 0) && (rdq.size() == 0);
    acc  = bus.chk_req && rdy;
    busy = (rdq.size() != 0) || acc;
    ns   = m_state;
    m_valid = 0;
    if (rdq.size() != 0) begin
      m_data  = cpu_data(rdq.pop_front());
      m_valid = 1;
    end
    if (acc) begin
      m_addr = bus.chk_addr;
      rdq.push_back(bus.chk_addr);
    end
    if (m_state != 0) m_cnt = (m_cnt + 1) % CNT_MOD;
    if (m_state == 0) begin
      if (!busy && bus.step) ns = 2;
      else if (!busy && bus.run) ns = 1;
    end else if (m_state == 1) begin
      if (bus.halt || !bus.run) ns = 0;
      else if (BRK_EN && (bus.next_pc == bus.brk_pc)) begin
        ns = 0;
        m_brk = 1;
      end
    end else begin
      ns = 0;
    end
    if (m_state == 0 && ns != 0) m_brk = 0;
    m_state = ns;
  endtask

  typedef struct {
    logic        run, step, halt, req;
    logic [31:0] addr;
    logic [1:0]  st;
    logic        en, rdy, val;
    logic [31:0] data;
    logic [31:0] caddr;
    logic [7:0]  cnt;
  } vec_t;

  vec_t        vt[15];
  logic [31:0] trig_pc;
  bit          ok;
  int          en_cycles;
  bit          run_r;

  initial begin
    // run step halt req addr | state en rdy val data caddr cnt
    vt[0]  = '{0,0,0,0,32'h0,    2'd0,0,1,0,32'h0,         32'h0,    8'd0};
    vt[1]  = '{0,1,0,0,32'h0,    2'd2,1,0,0,32'h0,         32'h0,    8'd0};
    vt[2]  = '{0,0,0,0,32'h0,    2'd0,0,1,0,32'h0,         32'h0,    8'd1};
    vt[3]  = '{1,0,0,0,32'h0,    2'd1,1,0,0,32'h0,         32'h0,    8'd1};
    vt[4]  = '{1,0,0,0,32'h0,    2'd1,1,0,0,32'h0,         32'h0,    8'd2};
    vt[5]  = '{1,0,1,0,32'h0,    2'd0,0,1,0,32'h0,         32'h0,    8'd3};
    vt[6]  = '{1,0,0,0,32'h0,    2'd1,1,0,0,32'h0,         32'h0,    8'd3};
    vt[7]  = '{0,0,0,0,32'h0,    2'd0,0,1,0,32'h0,         32'h0,    8'd4};
    vt[8]  = '{0,0,0,1,32'h1005, 2'd0,0,0,0,32'h0,         32'h1005, 8'd4};
    vt[9]  = '{0,1,0,0,32'h0,    2'd0,0,1,1,32'hDEAD_BEEF, 32'h1005, 8'd4};
    vt[10] = '{0,1,0,1,32'h1003, 2'd0,0,0,0,32'hDEAD_BEEF, 32'h1003, 8'd4};
    vt[11] = '{1,0,0,0,32'h0,    2'd0,0,1,1,32'h1234_5678, 32'h1003, 8'd4};
    vt[12] = '{1,0,0,0,32'h0,    2'd1,1,0,0,32'h1234_5678, 32'h1003, 8'd4};
    vt[13] = '{1,0,0,1,32'h1007, 2'd1,1,0,0,32'h1234_5678, 32'h1003, 8'd5};
    vt[14] = '{0,0,0,0,32'h0,    2'd0,0,1,0,32'h1234_5678, 32'h1003, 8'd6};

    bus.brk_pc = 32'hFFFF_FFF0;
    do_reset(32'h0);
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_cpu_en", 32'(bus.cpu_en), 32'd0);
    check("rst_cnt", 32'(bus.cyc_cnt), 32'd0);
    check("rst_brk", 32'(bus.brk_hit), 32'd0);

    for (int i = 0; i < 15; i++) begin
      bus.run = vt[i].run; bus.step = vt[i].step; bus.halt = vt[i].halt;
      bus.chk_req = vt[i].req; bus.chk_addr = vt[i].addr;
      tick();
      check($sformatf("v%0d_state", i), 32'(bus.state), 32'(vt[i].st));
      check($sformatf("v%0d_en", i), 32'(bus.cpu_en), 32'(vt[i].en));
      check($sformatf("v%0d_rdy", i), 32'(bus.chk_ready), 32'(vt[i].rdy));
      check($sformatf("v%0d_val", i), 32'(bus.chk_valid), 32'(vt[i].val));
      check($sformatf("v%0d_data", i), bus.chk_data, vt[i].data);
      check($sformatf("v%0d_caddr", i), bus.cpu_check_addr, vt[i].caddr);
      check($sformatf("v%0d_cnt", i), 32'(bus.cyc_cnt), 32'(vt[i].cnt));
    end
    idle();

    // Ten cycles of run
    do_reset(32'h0);
    en_cycles = 0;
    bus.run = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 10) bus.run = 1'b0;
      tick();
      if (bus.cpu_en) en_cycles++;
    end
    check("run10_en_cycles", 32'(en_cycles), 32'd10);
    check("run10_cnt", 32'(bus.cyc_cnt), 32'd10);
    check("run10_state", 32'(bus.state), 32'd0);

`ifdef PDU_BRKPT_EN
    do_reset(32'h3000);
    bus.brk_pc = 32'h3010;
    bus.run = 1'b1;
    ok = 0;
    trig_pc = 32'h0;
    for (int i = 0; i < 20 && !ok; i++) begin
      trig_pc = cpu_pc;
      tick();
      if (bus.brk_hit) ok = 1;
    end
    check("brk_reached", 32'(ok), 32'd1);
    check("brk_trig_pc", trig_pc, 32'h300C);
    check("brk_state", 32'(bus.state), 32'd0);
    check("brk_not_exec", cpu_pc, 32'h3010);
    tick();
    check("brk_clear", 32'(bus.brk_hit), 32'd0);
    check("brk_resume_state", 32'(bus.state), 32'd1);
    tick();
    check("brk_resume_pc", cpu_pc, 32'h3014);
    bus.brk_pc = 32'h3014;
    self_loop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("loop%0d_state", i), 32'(bus.state), (i % 2 == 0) ? 32'd0 : 32'd1);
      check($sformatf("loop%0d_brk", i), 32'(bus.brk_hit), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    self_loop = 1'b0;
`else
    do_reset(32'h3000);
    bus.brk_pc = 32'h3010;
    bus.run = 1'b1;
    repeat (8) tick();
    check("nobrk_state", 32'(bus.state), 32'd1);
    check("nobrk_brk", 32'(bus.brk_hit), 32'd0);
    check("nobrk_pc", cpu_pc, 32'h301C);
`endif
    idle();
    bus.brk_pc = 32'hFFFF_FFF0;

    // Counter wrap, then reset during a pending read
    do_reset(32'h100);
    bus.chk_req = 1'b1; bus.chk_addr = 32'h1005;
    tick();
    bus.chk_req = 1'b0;
    tick();
    check("pre_rd_val", 32'(bus.chk_valid), 32'd1);
    check("pre_rd_data", bus.chk_data, 32'hDEAD_BEEF);
    bus.run = 1'b1;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      if (bus.cyc_cnt == 8'hFF) ok = 1;
    end
    check("cnt_reach_max", 32'(ok), 32'd1);
    tick();
    check("cnt_wrap", 32'(bus.cyc_cnt), 32'd0);
    tick();
    bus.run = 1'b0;
    tick();
    check("wrap_halt", 32'(bus.state), 32'd0);
    bus.chk_req = 1'b1; bus.chk_addr = 32'h1003;
    tick();
    bus.chk_req = 1'b0;
    check("mid_rd_pending", 32'(bus.chk_ready), 32'd0);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_state", 32'(bus.state), 32'd0);
    check("arst_en", 32'(bus.cpu_en), 32'd0);
    check("arst_caddr", bus.cpu_check_addr, 32'h0);
    check("arst_data", bus.chk_data, 32'h0);
    check("arst_val", 32'(bus.chk_valid), 32'd0);
    check("arst_brk", 32'(bus.brk_hit), 32'd0);
    check("arst_cnt", 32'(bus.cyc_cnt), 32'd0);
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_rst%0d_val", i), 32'(bus.chk_valid), 32'd0);
      check($sformatf("post_rst%0d_state", i), 32'(bus.state), 32'd0);
      check($sformatf("post_rst%0d_cnt", i), 32'(bus.cyc_cnt), 32'd0);
    end

    // Random traffic against the model
    do_reset(32'h2000);
    bus.brk_pc = 32'h2010;
    model_reset();
    run_r = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 15) == 0) run_r = ~run_r;
      if ($urandom_range(0, 31) == 0) self_loop = ~self_loop;
      if ($urandom_range(0, 7) == 0) bus.brk_pc = cpu_pc + 32'(4 * $urandom_range(0, 3));
      bus.run      = run_r;
      bus.step     = ($urandom_range(0, 7) == 0);
      bus.halt     = ($urandom_range(0, 19) == 0);
      bus.chk_req  = ($urandom_range(0, 3) == 0);
      bus.chk_addr = {19'h0, 1'($urandom_range(0, 1)), 7'h0, 5'($urandom_range(0, 31))};
      #1;
      model_edge();
      tick();
      check($sformatf("r%0d_state", c), 32'(bus.state), 32'(m_state));
      check($sformatf("r%0d_en", c), 32'(bus.cpu_en), (m_state != 0) ? 32'd1 : 32'd0);
      check($sformatf("r%0d_brk", c), 32'(bus.brk_hit), 32'(m_brk));
      check($sformatf("r%0d_cnt", c), 32'(bus.cyc_cnt), 32'(m_cnt));
      check($sformatf("r%0d_rdy", c), 32'(bus.chk_ready),
            ((m_state == 0) && (rdq.size() == 0)) ? 32'd1 : 32'd0);
      check($sformatf("r%0d_val", c), 32'(bus.chk_valid), 32'(m_valid));
      check($sformatf("r%0d_data", c), bus.chk_data, m_data);
      check($sformatf("r%0d_caddr", c), bus.cpu_check_addr, m_addr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
